// File: rtl/sys_defs.sv
// sys_defs: definitions shared by the execute-stage blocks.
// Contents: DATA and ALU_FUNC types, the physical-register and ROB index
// widths and types, and the CDB packet that the buffers hand to the CDB arbiter.
package sys_defs;

    typedef logic [31:0] DATA;

    localparam int SYS_PREG_W = 6;
    localparam int SYS_ROB_W  = 5;

    typedef logic [SYS_PREG_W-1:0] PREG_IDX;
    typedef logic [SYS_ROB_W-1:0]  ROB_IDX;

    // Codes 4'hA..4'hF are unused. The ALU returns ALU_BAD_RESULT for them.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } ALU_FUNC;

    localparam DATA ALU_BAD_RESULT = 32'hfacebeec;

    typedef struct packed {
        DATA     result;
        PREG_IDX preg;
        ROB_IDX  rob_idx;
    } CDB_PACKET;

endpackage

// File: rtl/alu.sv
// alu: a purely combinational 32-bit integer ALU.
// Ports: opa, opb (operands), func (operation select), result.
// Arithmetic wraps on overflow. Shift amounts use opb[4:0].
module alu
    import sys_defs::*;
(
    input  DATA     opa,
    input  DATA     opb,
    input  ALU_FUNC func,
    output DATA     result
);

    always_comb begin
        result = ALU_BAD_RESULT;
        case (func)
            ALU_ADD:  result = opa + opb;
            ALU_SUB:  result = opa - opb;
            ALU_AND:  result = opa & opb;
            ALU_OR:   result = opa | opb;
            ALU_XOR:  result = opa ^ opb;
            ALU_SLL:  result = opa << opb[4:0];
            ALU_SRL:  result = opa >> opb[4:0];
            ALU_SRA:  result = DATA'($signed(opa) >>> opb[4:0]);
            ALU_SLT:  result = {31'b0, ($signed(opa) < $signed(opb))};
            ALU_SLTU: result = {31'b0, (opa < opb)};
            default:  result = ALU_BAD_RESULT;
        endcase
    end

endmodule

// File: rtl/alu_cdb_buffer.sv
// alu_cdb_buffer: the completion stage of the ALU functional unit.
// Issued ops are evaluated by the alu in the cycle they are accepted. Each
// result is written into an in-order FIFO. The FIFO head requests the CDB
// and is held stable until a grant pops it. A squash empties the FIFO.
// Ports:
//   clock, reset (async, active high)
//   issue_valid/issue_ready, opa, opb, alu_func, dest_preg, rob_idx  - issue side
//   squash                                                           - mispredict flush
//   cdb_req/cdb_grant, cdb_result, cdb_preg, cdb_rob_idx             - CDB side
//   count                                                            - occupancy
module alu_cdb_buffer
    import sys_defs::*;
#(
    parameter int DEPTH  = 4,
    parameter int PREG_W = SYS_PREG_W,
    parameter int ROB_W  = SYS_ROB_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  DATA                        opa,
    input  DATA                        opb,
    input  ALU_FUNC                    alu_func,
    input  logic [PREG_W-1:0]          dest_preg,
    input  logic [ROB_W-1:0]           rob_idx,
    input  logic                       squash,
    output logic                       cdb_req,
    input  logic                       cdb_grant,
    output DATA                        cdb_result,
    output logic [PREG_W-1:0]          cdb_preg,
    output logic [ROB_W-1:0]           cdb_rob_idx,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    DATA               r_res  [DEPTH];
    logic [PREG_W-1:0] r_preg [DEPTH];
    logic [ROB_W-1:0]  r_rob  [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    DATA               w_alu_result;
    logic              w_push;
    logic              w_pop;

    alu u_alu (
        .opa    (opa),
        .opb    (opb),
        .func   (alu_func),
        .result (w_alu_result)
    );

    // issue_ready looks only at the registered count. A pop in the same
    // cycle does not free a slot for issue until the next cycle.
    assign issue_ready = (r_count != CNT_W'(DEPTH));
    assign cdb_req     = (r_count != '0);
    assign count       = r_count;

    // A squash overrides both handshakes in the same cycle.
    assign w_push = issue_valid && issue_ready && !squash;
    assign w_pop  = cdb_req && cdb_grant && !squash;

    // The fields come straight from the head entry. Nothing is written to
    // the head entry while it is occupied, so the fields stay stable until the pop.
    assign cdb_result  = cdb_req ? r_res[r_head]  : '0;
    assign cdb_preg    = cdb_req ? r_preg[r_head] : '0;
    assign cdb_rob_idx = cdb_req ? r_rob[r_head]  : '0;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The storage has no reset. Entries outside [head, head+count) are never observed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_res[r_tail]  <= w_alu_result;
            r_preg[r_tail] <= dest_preg;
            r_rob[r_tail]  <= rob_idx;
        end
    end

endmodule

// File: tb/tb_alu_cdb_buffer.sv
// Bench for alu_cdb_buffer. The driver pushes the hand-computed expected
// packet for each accepted op onto a queue. The monitor pops and compares
// it on every CDB pop.
module tb_alu_cdb_buffer;
    import sys_defs::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    DATA         opa, opb;
    ALU_FUNC     alu_func;
    logic [5:0]  dest_preg;
    logic [4:0]  rob_idx;
    logic        squash;
    logic        cdb_req;
    logic        cdb_grant;
    DATA         cdb_result;
    logic [5:0]  cdb_preg;
    logic [4:0]  cdb_rob_idx;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [42:0] sb[$];

    alu_cdb_buffer #(.DEPTH(4), .PREG_W(6), .ROB_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opa         (opa),
        .opb         (opb),
        .alu_func    (alu_func),
        .dest_preg   (dest_preg),
        .rob_idx     (rob_idx),
        .squash      (squash),
        .cdb_req     (cdb_req),
        .cdb_grant   (cdb_grant),
        .cdb_result  (cdb_result),
        .cdb_preg    (cdb_preg),
        .cdb_rob_idx (cdb_rob_idx),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge. Return at the
    // falling edge, where the bench decides whether the DUT will accept the op.
    task automatic drive(input logic iv, input ALU_FUNC f, input DATA a, input DATA b,
                         input DATA exp, input logic [5:0] p, input logic [4:0] r,
                         input logic g, input logic sq, output logic acc);
        @(posedge clock);
        #1;
        issue_valid = iv; alu_func = f; opa = a; opb = b;
        dest_preg = p; rob_idx = r; cdb_grant = g; squash = sq;
        @(negedge clock);
        acc = iv && issue_ready && !sq;
        if (acc) sb.push_back({exp, p, r});
    endtask

    task automatic idle(input logic g);
        logic acc;
        drive(1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0, 6'h0, 5'h0, g, 1'b0, acc);
    endtask

    // Monitor: every CDB pop is compared against the oldest expected packet.
    always @(negedge clock) begin
        if (!reset) begin
            if (squash) begin
                sb.delete();
            end else if (cdb_req && cdb_grant) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cdb_unexpected: got %0h expected no request",
                             {cdb_result, cdb_preg, cdb_rob_idx});
                end else begin
                    check("cdb_pkt", 64'({cdb_result, cdb_preg, cdb_rob_idx}), 64'(sb.pop_front()));
                end
            end else if (!cdb_req) begin
                check("empty_fields", 64'({cdb_result, cdb_preg, cdb_rob_idx}), 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    ALU_FUNC   vf[10];
    DATA       va[10], vb[10], ve[10];

    initial begin
        logic acc;
        int   tries;

        vf[0] = ALU_ADD;  va[0] = 32'h7fffffff; vb[0] = 32'h1;        ve[0] = 32'h80000000;
        vf[1] = ALU_SUB;  va[1] = 32'h0;        vb[1] = 32'h1;        ve[1] = 32'hffffffff;
        vf[2] = ALU_AND;  va[2] = 32'hf0f0f0f0; vb[2] = 32'hff00ff00; ve[2] = 32'hf000f000;
        vf[3] = ALU_OR;   va[3] = 32'h00ff0000; vb[3] = 32'h000000ff; ve[3] = 32'h00ff00ff;
        vf[4] = ALU_XOR;  va[4] = 32'haaaaaaaa; vb[4] = 32'h55555555; ve[4] = 32'hffffffff;
        vf[5] = ALU_SLL;  va[5] = 32'h1;        vb[5] = 32'd31;       ve[5] = 32'h80000000;
        vf[6] = ALU_SRL;  va[6] = 32'h80000000; vb[6] = 32'd31;       ve[6] = 32'h1;
        vf[7] = ALU_SRA;  va[7] = 32'hf0000000; vb[7] = 32'd28;       ve[7] = 32'hffffffff;
        vf[8] = ALU_SLT;  va[8] = 32'd5;        vb[8] = 32'hfffffffd; ve[8] = 32'h0;
        vf[9] = ALU_SLTU; va[9] = 32'd5;        vb[9] = 32'hfffffffd; ve[9] = 32'h1;

        reset = 1'b1; issue_valid = 1'b0; opa = '0; opb = '0; alu_func = ALU_ADD;
        dest_preg = '0; rob_idx = '0; squash = 1'b0; cdb_grant = 1'b0;
        #12;
        check("rst_req",   64'(cdb_req), 64'd0);
        check("rst_ready", 64'(issue_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_fields", 64'({cdb_result, cdb_preg, cdb_rob_idx}), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single ADD with the grant held high
        drive(1'b1, ALU_ADD, 32'd5, 32'd7, 32'd12, 6'd3, 5'd2, 1'b1, 1'b0, acc);
        idle(1'b1);
        check("lat_req", 64'(cdb_req), 64'd1);
        idle(1'b1);
        check("single_req",   64'(cdb_req), 64'd0);
        check("single_count", 64'(count), 64'd0);

        // Fill the buffer to full with no grants
        drive(1'b1, ALU_SUB,  32'd1, 32'd2, 32'hffffffff, 6'd4, 5'd4, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_SLT,  32'hffffffff, 32'd1, 32'd1, 6'd5, 5'd5, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_SRA,  32'h80000000, 32'd4, 32'hf8000000, 6'd6, 5'd6, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_SLTU, 32'd1, 32'd0, 32'd0, 6'd7, 5'd7, 1'b0, 1'b0, acc);
        idle(1'b0);
        check("full_ready", 64'(issue_ready), 64'd0);
        check("full_count", 64'(count), 64'd4);

        // Full buffer: an issue and a grant in the same cycle. Only the pop takes effect.
        drive(1'b1, ALU_ADD, 32'd1, 32'd1, 32'd2, 6'd8, 5'd8, 1'b1, 1'b0, acc);
        check("full_noaccept", 64'(acc), 64'd0);
        idle(1'b0);
        check("fullpop_count", 64'(count), 64'd3);
        check("fullpop_ready", 64'(issue_ready), 64'd1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        idle(1'b0);
        check("drain_count", 64'(count), 64'd0);

        // Push and pop in the same cycle at count=2
        drive(1'b1, ALU_AND, 32'hff, 32'h0f, 32'h0f, 6'd9,  5'd9,  1'b0, 1'b0, acc);
        drive(1'b1, ALU_OR,  32'hf0, 32'h0f, 32'hff, 6'd10, 5'd10, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_SLL, 32'h1,  32'd4,  32'h10, 6'd11, 5'd11, 1'b1, 1'b0, acc);
        idle(1'b0);
        check("pushpop_count", 64'(count), 64'd2);
        idle(1'b1); idle(1'b1);
        idle(1'b0);
        check("pushpop_drain", 64'(count), 64'd0);

        // Ten ops through the wrap point, with random grants
        for (int i = 0; i < 10; i++) begin
            tries = 0;
            do begin
                drive(1'b1, vf[i], va[i], vb[i], ve[i], 6'(i), 5'(i + 10),
                      1'($urandom_range(0, 1)), 1'b0, acc);
                tries++;
            end while (!acc && tries < 50);
            check("wrap_accept", 64'(acc), 64'd1);
        end
        tries = 0;
        while (count != 0 && tries < 50) begin
            idle(1'b1);
            tries++;
        end
        check("wrap_drain", 64'(count), 64'd0);

        // Squash with three entries, plus an issue and a grant in the same cycle
        drive(1'b1, ALU_ADD, 32'd1, 32'd1, 32'd2, 6'd1, 5'd1, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_ADD, 32'd2, 32'd2, 32'd4, 6'd2, 5'd2, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_ADD, 32'd3, 32'd3, 32'd6, 6'd3, 5'd3, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_ADD, 32'd9, 32'd9, 32'd18, 6'd4, 5'd4, 1'b1, 1'b1, acc);
        idle(1'b1);
        check("squash_count", 64'(count), 64'd0);
        check("squash_req",   64'(cdb_req), 64'd0);
        idle(1'b1);

        // Unknown operation code
        drive(1'b1, ALU_FUNC'(4'hf), 32'd3, 32'd4, 32'hfacebeec, 6'd5, 5'd5, 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset between clock edges while entries are held
        drive(1'b1, ALU_ADD, 32'd2, 32'd3, 32'd5, 6'd6, 5'd6, 1'b0, 1'b0, acc);
        drive(1'b1, ALU_ADD, 32'd4, 32'd4, 32'd8, 6'd7, 5'd7, 1'b0, 1'b0, acc);
        issue_valid = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        sb.delete();
        #1;
        check("arst_req",    64'(cdb_req), 64'd0);
        check("arst_count",  64'(count), 64'd0);
        check("arst_ready",  64'(issue_ready), 64'd1);
        check("arst_fields", 64'({cdb_result, cdb_preg, cdb_rob_idx}), 64'd0);
        reset = 1'b0;
        drive(1'b1, ALU_XOR, 32'hf0, 32'hff, 32'h0f, 6'd12, 5'd12, 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b0);
        check("final_count", 64'(count), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
